inning_controller: RTL and testbench
====================================

Name: inning_controller

Overview:
Game sequencer for the baseball-game lab. It accepts one play event per handshake and keeps the ball, strike and out counts, the base runners and the per-team score. It sequences half-innings and innings and detects end of game. Its runner outputs drive the scoreboard display directly.

Parameters:
NUM_INNINGS, 9, regulation innings; inning counter runs 1..NUM_INNINGS
SCORE_W, 5, score width per team; score saturates at 2^SCORE_W-1
INN_W, 4, inning counter width; must hold NUM_INNINGS

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
new_game  in  1  synchronous restart pulse, highest priority after reset
evt_valid  in  1  play event offered
evt_code  in  3  0 ball, 1 strike, 2 foul, 3 out, 4 single, 5 double, 6 triple, 7 homerun
evt_ready  out  1  block can accept an event
ball_count  out  2  balls 0..3
strike_count  out  2  strikes 0..2
out_count  out  2  outs 0..2
runner_1st / runner_2nd / runner_3rd  out  1 each  base occupied
score_away / score_home  out  SCORE_W each  runs per team
inning  out  INN_W  current inning, starts at 1
half  out  1  0 top (away bats), 1 bottom (home bats)
runs_scored  out  3  runs credited by the last accepted event; valid while runs_pulse=1
runs_pulse  out  1  one-cycle pulse when runs_scored>0
game_over  out  1  game finished

Behaviour:
- Reset or new_game: state PLAY; all counts, runners and scores 0; inning=1; half=0; runs_pulse=0; game_over=0; evt_ready=1.
- FSM states: PLAY, SWITCH, OVER. evt_ready=1 only in PLAY.
- Accept = evt_valid & evt_ready. Every output updates at the next rising edge (1-cycle latency). With evt_valid low, nothing changes.
- ball: if balls<3, balls+1. Otherwise walk, counts cleared, forced advance: 1st=1, 2nd=r2|r1, 3rd=r3|(r1&r2), runs=r1&r2&r3.
- strike: strikes+1 if <2; else strikeout (same effect as out).
- foul: strikes+1 if <2; else no change.
- out: counts cleared; if outs<2, outs+1, runners kept; if outs==2, go to SWITCH.
- single: 3rd=r2, 2nd=r1, 1st=1, runs=r3. double: 3rd=r1, 2nd=1, 1st=0, runs=r2+r3. triple: 3rd=1, others 0, runs=r1+r2+r3. homerun: all bases clear, runs=r1+r2+r3+1. Every hit clears the count.
- Runs are added to the batting team (half=0 away, 1 home), saturating at max. runs_pulse is high for one cycle with runs_scored.
- SWITCH, one cycle: outs, counts and runners cleared. Exit conditions, first match wins:
  - half=0, inning=NUM_INNINGS, home>away: OVER.
  - half=1, inning>=NUM_INNINGS: OVER.
  - Otherwise: PLAY, half toggles, inning+1 when half goes 1->0.
- Walk-off: in PLAY with half=1 and inning>=NUM_INNINGS, any event leaving home>away goes directly to OVER at the same edge.
- OVER: game_over=1, evt_ready=0. Held until new_game or reset.
- An evt_valid held while evt_ready=0 is ignored, not queued.
- rst_n asserted mid-event discards the event.

Optional Feature:
EXTRA_INNINGS_EN. When defined, a tie at the end of the bottom of inning >=NUM_INNINGS goes PLAY to the top of the next inning instead of OVER. The inning counter saturates at 2^INN_W-1, and the game ends there regardless of score. When undefined, the game ends tied after the bottom of NUM_INNINGS.

Decomposition:
- Package baseball_pkg: evt_code localparams (EVT_BALL..EVT_HOMERUN), FSM state encodings, HALF_TOP/HALF_BOTTOM.
- Sub-module base_advance (combinational): inputs evt_code, walk flag and r1/r2/r3; outputs next runners and 3-bit runs. Tested standalone.

Test Plan:
- Reset, then 4 balls with empty bases -> runner_1st=1, counts 0, runs_pulse never high.
- Bases loaded, then single -> runners 1/1/1, score_away=1, runs_scored=1 with a 1-cycle runs_pulse.
- Bases loaded, then homerun -> runners 0, score_away=4, runs_scored=4.
- 3 outs in the top of inning 1 -> evt_ready low for 1 cycle (SWITCH), then half=1, inning=1, runners cleared. 3 more outs -> inning=2, half=0.
- Tie entering the bottom of inning 9, home single with runner on 3rd -> score_home+1, game_over=1 at the same edge, evt_ready=0.
- Tie after the bottom of inning 9 -> game_over=1 without EXTRA_INNINGS_EN; with the macro, inning=10, half=0. new_game then restores inning=1 and scores 0.

Source files
------------

// File: rtl/baseball_pkg.sv
// Shared event codes, FSM encoding and half-inning constants for the game sequencer.
package baseball_pkg;

    localparam logic [2:0] EVT_BALL    = 3'd0;
    localparam logic [2:0] EVT_STRIKE  = 3'd1;
    localparam logic [2:0] EVT_FOUL    = 3'd2;
    localparam logic [2:0] EVT_OUT     = 3'd3;
    localparam logic [2:0] EVT_SINGLE  = 3'd4;
    localparam logic [2:0] EVT_DOUBLE  = 3'd5;
    localparam logic [2:0] EVT_TRIPLE  = 3'd6;
    localparam logic [2:0] EVT_HOMERUN = 3'd7;

    localparam logic HALF_TOP    = 1'b0;
    localparam logic HALF_BOTTOM = 1'b1;

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_OVER   = 2'd2
    } state_e;

    function automatic logic [2:0] runner_sum(input logic r1, input logic r2, input logic r3);
        return {2'b00, r1} + {2'b00, r2} + {2'b00, r3};
    endfunction

endpackage

// File: rtl/base_advance.sv
// Combinational runner advancement for walks and hits; other events pass runners through.
module base_advance
    import baseball_pkg::*;
(
    input  logic [2:0] evt_code,
    input  logic       walk,
    input  logic       r1_i,
    input  logic       r2_i,
    input  logic       r3_i,
    output logic       r1_o,
    output logic       r2_o,
    output logic       r3_o,
    output logic [2:0] runs_o
);

    // Next runner positions and runs credited for the offered event
    always_comb begin
        r1_o   = r1_i;
        r2_o   = r2_i;
        r3_o   = r3_i;
        runs_o = 3'd0;
        if (walk) begin
            // Runners only move when forced by the runner behind them
            r1_o   = 1'b1;
            r2_o   = r2_i | r1_i;
            r3_o   = r3_i | (r1_i & r2_i);
            runs_o = {2'b00, r1_i & r2_i & r3_i};
        end else begin
            case (evt_code)
                EVT_SINGLE: begin
                    r1_o   = 1'b1;
                    r2_o   = r1_i;
                    r3_o   = r2_i;
                    runs_o = {2'b00, r3_i};
                end
                EVT_DOUBLE: begin
                    r1_o   = 1'b0;
                    r2_o   = 1'b1;
                    r3_o   = r1_i;
                    runs_o = runner_sum(1'b0, r2_i, r3_i);
                end
                EVT_TRIPLE: begin
                    r1_o   = 1'b0;
                    r2_o   = 1'b0;
                    r3_o   = 1'b1;
                    runs_o = runner_sum(r1_i, r2_i, r3_i);
                end
                EVT_HOMERUN: begin
                    r1_o   = 1'b0;
                    r2_o   = 1'b0;
                    r3_o   = 1'b0;
                    runs_o = runner_sum(r1_i, r2_i, r3_i) + 3'd1;
                end
                default: begin
                    r1_o   = r1_i;
                    r2_o   = r2_i;
                    r3_o   = r3_i;
                    runs_o = 3'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/inning_controller.sv
// Game sequencer: counts, runners, scores, half-inning/inning sequencing and end of game.
// Optional macro EXTRA_INNINGS_EN: a tie after regulation continues into extra innings.
module inning_controller
    import baseball_pkg::*;
#(
    parameter int NUM_INNINGS = 9,
    parameter int SCORE_W     = 5,
    parameter int INN_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_game,
    input  logic               evt_valid,
    input  logic [2:0]         evt_code,
    output logic               evt_ready,
    output logic [1:0]         ball_count,
    output logic [1:0]         strike_count,
    output logic [1:0]         out_count,
    output logic               runner_1st,
    output logic               runner_2nd,
    output logic               runner_3rd,
    output logic [SCORE_W-1:0] score_away,
    output logic [SCORE_W-1:0] score_home,
    output logic [INN_W-1:0]   inning,
    output logic               half,
    output logic [2:0]         runs_scored,
    output logic               runs_pulse,
    output logic               game_over
);

    localparam logic [INN_W-1:0]   INN_ONE   = INN_W'(1);
    localparam logic [INN_W-1:0]   INN_LAST  = INN_W'(NUM_INNINGS);
    localparam logic [INN_W-1:0]   INN_MAX   = {INN_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_e             state_q, state_d;
    logic [1:0]         balls_q, balls_d;
    logic [1:0]         strikes_q, strikes_d;
    logic [1:0]         outs_q, outs_d;
    logic               r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic [SCORE_W-1:0] away_q, away_d, home_q, home_d;
    logic [INN_W-1:0]   inning_q, inning_d;
    logic               half_q, half_d;
    logic [2:0]         runs_q, runs_d;
    logic               pulse_q, pulse_d;

    logic               walk_s, out_evt_s, walkoff_s;
    logic               adv_r1_s, adv_r2_s, adv_r3_s;
    logic [2:0]         adv_runs_s;
    logic [SCORE_W-1:0] away_sum_s, home_sum_s;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [2:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {{(SCORE_W-2){1'b0}}, b};
        return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

    assign walk_s = (evt_code == EVT_BALL) && (balls_q == 2'd3);

    base_advance u_base_advance (
        .evt_code (evt_code),
        .walk     (walk_s),
        .r1_i     (r1_q),
        .r2_i     (r2_q),
        .r3_i     (r3_q),
        .r1_o     (adv_r1_s),
        .r2_o     (adv_r2_s),
        .r3_o     (adv_r3_s),
        .runs_o   (adv_runs_s)
    );

    // Candidate scores if the offered event is accepted, and the walk-off test on them
    always_comb begin
        away_sum_s = away_q;
        home_sum_s = home_q;
        if (half_q == HALF_TOP) begin
            away_sum_s = sat_add(away_q, adv_runs_s);
        end else begin
            home_sum_s = sat_add(home_q, adv_runs_s);
        end
        walkoff_s = (half_q == HALF_BOTTOM) && (inning_q >= INN_LAST) && (home_sum_s > away_sum_s);
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        balls_d   = balls_q;
        strikes_d = strikes_q;
        outs_d    = outs_q;
        r1_d      = r1_q;
        r2_d      = r2_q;
        r3_d      = r3_q;
        away_d    = away_q;
        home_d    = home_q;
        inning_d  = inning_q;
        half_d    = half_q;
        runs_d    = 3'd0;
        pulse_d   = 1'b0;
        out_evt_s = 1'b0;
        if (new_game) begin
            state_d   = ST_PLAY;
            balls_d   = 2'd0;
            strikes_d = 2'd0;
            outs_d    = 2'd0;
            r1_d      = 1'b0;
            r2_d      = 1'b0;
            r3_d      = 1'b0;
            away_d    = '0;
            home_d    = '0;
            inning_d  = INN_ONE;
            half_d    = HALF_TOP;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (evt_valid) begin
                        r1_d    = adv_r1_s;
                        r2_d    = adv_r2_s;
                        r3_d    = adv_r3_s;
                        away_d  = away_sum_s;
                        home_d  = home_sum_s;
                        runs_d  = adv_runs_s;
                        pulse_d = (adv_runs_s != 3'd0);
                        case (evt_code)
                            EVT_BALL: begin
                                if (balls_q != 2'd3) begin
                                    balls_d = balls_q + 2'd1;
                                end else begin
                                    balls_d   = 2'd0;
                                    strikes_d = 2'd0;
                                end
                            end
                            EVT_STRIKE: begin
                                if (strikes_q != 2'd2) begin
                                    strikes_d = strikes_q + 2'd1;
                                end else begin
                                    out_evt_s = 1'b1;
                                end
                            end
                            EVT_FOUL: begin
                                if (strikes_q != 2'd2) begin
                                    strikes_d = strikes_q + 2'd1;
                                end else begin
                                    strikes_d = strikes_q;
                                end
                            end
                            EVT_OUT: begin
                                out_evt_s = 1'b1;
                            end
                            default: begin
                                balls_d   = 2'd0;
                                strikes_d = 2'd0;
                            end
                        endcase
                        if (out_evt_s) begin
                            balls_d   = 2'd0;
                            strikes_d = 2'd0;
                            if (outs_q != 2'd2) begin
                                outs_d = outs_q + 2'd1;
                            end else begin
                                outs_d = outs_q;
                            end
                        end else begin
                            outs_d = outs_q;
                        end
                        // A walk-off wins over a simultaneous third out
                        if (walkoff_s) begin
                            state_d = ST_OVER;
                        end else if (out_evt_s && (outs_q == 2'd2)) begin
                            state_d = ST_SWITCH;
                        end else begin
                            state_d = ST_PLAY;
                        end
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_SWITCH: begin
                    balls_d   = 2'd0;
                    strikes_d = 2'd0;
                    outs_d    = 2'd0;
                    r1_d      = 1'b0;
                    r2_d      = 1'b0;
                    r3_d      = 1'b0;
                    if (half_q == HALF_TOP) begin
                        if ((inning_q == INN_LAST) && (home_q > away_q)) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_PLAY;
                            half_d  = HALF_BOTTOM;
                        end
                    end else if (inning_q >= INN_LAST) begin
`ifdef EXTRA_INNINGS_EN
                        if ((home_q == away_q) && (inning_q != INN_MAX)) begin
                            state_d  = ST_PLAY;
                            half_d   = HALF_TOP;
                            inning_d = inning_q + INN_ONE;
                        end else begin
                            state_d = ST_OVER;
                        end
`else
                        state_d = ST_OVER;
`endif
                    end else begin
                        state_d  = ST_PLAY;
                        half_d   = HALF_TOP;
                        inning_d = (inning_q != INN_MAX) ? inning_q + INN_ONE : inning_q;
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_PLAY;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_PLAY;
            balls_q   <= 2'd0;
            strikes_q <= 2'd0;
            outs_q    <= 2'd0;
            r1_q      <= 1'b0;
            r2_q      <= 1'b0;
            r3_q      <= 1'b0;
            away_q    <= '0;
            home_q    <= '0;
            inning_q  <= INN_ONE;
            half_q    <= HALF_TOP;
            runs_q    <= 3'd0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            balls_q   <= balls_d;
            strikes_q <= strikes_d;
            outs_q    <= outs_d;
            r1_q      <= r1_d;
            r2_q      <= r2_d;
            r3_q      <= r3_d;
            away_q    <= away_d;
            home_q    <= home_d;
            inning_q  <= inning_d;
            half_q    <= half_d;
            runs_q    <= runs_d;
            pulse_q   <= pulse_d;
        end
    end

    assign evt_ready    = (state_q == ST_PLAY);
    assign game_over    = (state_q == ST_OVER);
    assign ball_count   = balls_q;
    assign strike_count = strikes_q;
    assign out_count    = outs_q;
    assign runner_1st   = r1_q;
    assign runner_2nd   = r2_q;
    assign runner_3rd   = r3_q;
    assign score_away   = away_q;
    assign score_home   = home_q;
    assign inning       = inning_q;
    assign half         = half_q;
    assign runs_scored  = runs_q;
    assign runs_pulse   = pulse_q;

endmodule

// File: tb/tb_inning_controller.sv
// Directed plus randomized bench for inning_controller against a rule-level game model.
module tb_inning_controller;

    localparam int NUM_INN = 9;
    localparam int SMAX    = 31;
    localparam int IMAX    = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_game = 1'b0;
    logic       evt_valid = 1'b0;
    logic [2:0] evt_code = 3'd0;
    logic       evt_ready, runner_1st, runner_2nd, runner_3rd, half, runs_pulse, game_over;
    logic [1:0] ball_count, strike_count, out_count;
    logic [4:0] score_away, score_home;
    logic [3:0] inning;
    logic [2:0] runs_scored;

    int n_cmp = 0;
    int n_bad = 0;

    // model: mode 0 play, 1 between halves, 2 game over
    int m_mode, m_balls, m_strikes, m_outs, m_away, m_home, m_inning, m_half, m_pulse, m_runs;
    int m_base[1:3];

    always #5 clk = ~clk;

    inning_controller dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game), .evt_valid(evt_valid), .evt_code(evt_code),
        .evt_ready(evt_ready), .ball_count(ball_count), .strike_count(strike_count),
        .out_count(out_count), .runner_1st(runner_1st), .runner_2nd(runner_2nd),
        .runner_3rd(runner_3rd), .score_away(score_away), .score_home(score_home),
        .inning(inning), .half(half), .runs_scored(runs_scored), .runs_pulse(runs_pulse),
        .game_over(game_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = 0; m_balls = 0; m_strikes = 0; m_outs = 0; m_away = 0; m_home = 0;
        m_inning = 1; m_half = 0; m_pulse = 0; m_runs = 0;
        for (int p = 1; p <= 3; p++) m_base[p] = 0;
    endtask

    task automatic m_step(input logic v, input logic [2:0] c, input logic ng);
        int runs;
        bit third;
        int k;
        int nb[1:3];
        runs = 0; third = 0; m_pulse = 0; m_runs = 0;
        if (ng) begin
            m_reset();
        end else if (m_mode == 0 && v) begin
            if (c == 3'd0) begin
                if (m_balls < 3) m_balls++;
                else begin
                    // batter takes first; fill the run of occupied bases up to the first gap
                    k = 0;
                    for (int p = 1; p <= 3; p++) if (k == 0 && m_base[p] == 0) k = p;
                    if (k == 0) runs = 1;
                    else for (int p = 1; p <= k; p++) m_base[p] = 1;
                    m_balls = 0; m_strikes = 0;
                end
            end else if (c == 3'd1 || c == 3'd2) begin
                if (m_strikes < 2) m_strikes++;
                else if (c == 3'd1) third = 1;
            end else if (c == 3'd3) begin
                third = 1;
            end else begin
                for (int p = 1; p <= 3; p++) nb[p] = 0;
                for (int p = 1; p <= 3; p++)
                    if (m_base[p] != 0) begin
                        if (p + int'(c) - 3 > 3) runs++;
                        else nb[p + int'(c) - 3] = 1;
                    end
                if (int'(c) - 3 > 3) runs++;
                else nb[int'(c) - 3] = 1;
                for (int p = 1; p <= 3; p++) m_base[p] = nb[p];
                m_balls = 0; m_strikes = 0;
            end
            // third holds "an out was recorded"; only the third one ends the half
            if (third) begin
                m_balls = 0; m_strikes = 0;
                if (m_outs < 2) begin m_outs++; third = 0; end
            end
            if (m_half == 0) m_away = (m_away + runs > SMAX) ? SMAX : m_away + runs;
            else             m_home = (m_home + runs > SMAX) ? SMAX : m_home + runs;
            m_runs = runs; m_pulse = (runs > 0);
            if (m_half == 1 && m_inning >= NUM_INN && m_home > m_away) m_mode = 2;
            else if (third) m_mode = 1;
        end else if (m_mode == 1) begin
            m_balls = 0; m_strikes = 0; m_outs = 0;
            for (int p = 1; p <= 3; p++) m_base[p] = 0;
            if (m_half == 0 && m_inning == NUM_INN && m_home > m_away) m_mode = 2;
            else if (m_half == 1 && m_inning >= NUM_INN) begin
`ifdef EXTRA_INNINGS_EN
                if (m_home == m_away && m_inning < IMAX) begin m_mode = 0; m_half = 0; m_inning++; end
                else m_mode = 2;
`else
                m_mode = 2;
`endif
            end else begin
                m_mode = 0;
                if (m_half == 1) begin m_half = 0; m_inning++; end
                else m_half = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("evt_ready", evt_ready, m_mode == 0);
        chk("game_over", game_over, m_mode == 2);
        chk("ball_count", ball_count, m_balls);
        chk("strike_count", strike_count, m_strikes);
        chk("out_count", out_count, m_outs);
        chk("runner_1st", runner_1st, m_base[1]);
        chk("runner_2nd", runner_2nd, m_base[2]);
        chk("runner_3rd", runner_3rd, m_base[3]);
        chk("score_away", score_away, m_away);
        chk("score_home", score_home, m_home);
        chk("inning", inning, m_inning);
        chk("half", half, m_half);
        chk("runs_pulse", runs_pulse, m_pulse);
        if (m_pulse != 0) chk("runs_scored", runs_scored, m_runs);
    endtask

    task automatic cycle(input logic v, input logic [2:0] c, input logic ng);
        evt_valid = v; evt_code = c; new_game = ng;
        @(posedge clk);
        m_step(v, c, ng);
        @(negedge clk);
        check_all();
    endtask

    task automatic half_out();
        repeat (3) cycle(1'b1, 3'd3, 1'b0);
        cycle(1'b1, 3'($urandom_range(0, 7)), 1'b0);
    endtask

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // four balls on empty bases
        repeat (4) cycle(1'b1, 3'd0, 1'b0);
        chk("walk_r1", runner_1st, 1);
        chk("walk_balls", ball_count, 0);

        // load the bases, then a single
        repeat (8) cycle(1'b1, 3'd0, 1'b0);
        cycle(1'b1, 3'd4, 1'b0);
        chk("single_away", score_away, 1);
        chk("single_runs", runs_scored, 1);
        chk("single_pulse", runs_pulse, 1);
        cycle(1'b0, 3'd0, 1'b0);
        chk("single_pulse_end", runs_pulse, 0);

        // grand slam from a fresh game
        cycle(1'b0, 3'd0, 1'b1);
        repeat (12) cycle(1'b1, 3'd0, 1'b0);
        cycle(1'b1, 3'd7, 1'b0);
        chk("slam_away", score_away, 4);
        chk("slam_runs", runs_scored, 4);
        chk("slam_r1", runner_1st, 0);

        // half-inning switch timing
        cycle(1'b0, 3'd0, 1'b1);
        repeat (3) cycle(1'b1, 3'd3, 1'b0);
        chk("switch_ready", evt_ready, 0);
        cycle(1'b1, 3'd7, 1'b0);
        chk("switch_half", half, 1);
        chk("switch_inning", inning, 1);
        chk("switch_ready_back", evt_ready, 1);
        half_out();
        chk("inning2", inning, 2);
        chk("inning2_half", half, 0);

        // walk-off in the bottom of the ninth
        cycle(1'b0, 3'd0, 1'b1);
        repeat (17) half_out();
        chk("b9_half", half, 1);
        chk("b9_inning", inning, 9);
        cycle(1'b1, 3'd6, 1'b0);
        cycle(1'b1, 3'd4, 1'b0);
        chk("walkoff_home", score_home, 1);
        chk("walkoff_over", game_over, 1);
        chk("walkoff_ready", evt_ready, 0);
        repeat (3) cycle(1'b1, 3'd7, 1'b0);

        // tie after regulation
        cycle(1'b0, 3'd0, 1'b1);
        repeat (18) half_out();
`ifdef EXTRA_INNINGS_EN
        chk("tie_inning", inning, 10);
        chk("tie_half", half, 0);
`else
        chk("tie_over", game_over, 1);
`endif
        cycle(1'b0, 3'd0, 1'b1);
        chk("newgame_inning", inning, 1);
        chk("newgame_away", score_away, 0);

        // score saturation
        repeat (35) cycle(1'b1, 3'd7, 1'b0);
        chk("sat_away", score_away, SMAX);

        // reset arriving during an offered event discards it
        evt_valid = 1'b1; evt_code = 3'd7; new_game = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        m_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // randomized play
        for (int i = 0; i < 6000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 399) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
